xs3_to_bcd_serial: RTL and testbench

Multi-digit Excess-3 to packed-BCD decoder: the receive-side counterpart of the team's BCD-to-Excess-3 encoder. It accepts a packed word of `DIGITS` Excess-3 codes over a valid/ready handshake and converts one digit per clock using a shift register and a digit counter. It flags invalid codes per digit and presents the BCD result on a valid/ready output port. It sits between the Excess-3 encoded datapath and BCD display/arithmetic logic.

---
 rtl/xs3_pkg.sv | 22 ++
 rtl/xs3_digit_dec.sv | 23 ++
 rtl/xs3_to_bcd_serial.sv | 107 ++++++++++
 tb/tb_xs3_to_bcd_serial.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// ============================================================================
// xs3_pkg : shared constants and FSM state type for the Excess-3 decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_MIN     = 4'd3;
  localparam logic [3:0] XS3_MAX     = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/xs3_digit_dec.sv
// ============================================================================
// xs3_digit_dec : single-digit Excess-3 to BCD decode with invalid-code flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  logic w_err;

  assign w_err = (code_i < XS3_MIN) || (code_i > XS3_MAX);
  assign err_o = w_err;
  assign bcd_o = w_err ? BCD_INVALID : (code_i - XS3_OFFSET);

endmodule

`default_nettype wire

// File: rtl/xs3_to_bcd_serial.sv
// ============================================================================
// xs3_to_bcd_serial : multi-digit Excess-3 to packed BCD, one digit per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module xs3_to_bcd_serial
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_xs3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);

  localparam int               W     = 4 * DIGITS;
  localparam int               CNT_W = $clog2(DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      sh_q, sh_d;
  logic [W-1:0]      bcd_q, bcd_d;
  logic [DIGITS-1:0] err_q, err_d;

  logic [3:0]        w_dig_bcd;
  logic              w_dig_err;
  logic [W+3:0]      w_bcd_cat;
  logic [DIGITS:0]   w_err_cat;

  xs3_digit_dec u_dec (
    .code_i (sh_q[3:0]),
    .bcd_o  (w_dig_bcd),
    .err_o  (w_dig_err)
  );

  // Decoded digit enters at the top so digit order matches the input after DIGITS shifts
  assign w_bcd_cat = {w_dig_bcd, bcd_q};
  assign w_err_cat = {w_dig_err, err_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_xs3;
          cnt_d   = '0;
          bcd_d   = '0;
          err_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = sh_q >> 4;
        bcd_d = w_bcd_cat[W+3:4];
        err_d = w_err_cat[DIGITS:1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = bcd_q;
  assign out_err_mask = err_q;
  assign out_err      = |err_q;

endmodule

`default_nettype wire

// File: tb/tb_xs3_to_bcd_serial.sv
// ============================================================================
// tb_xs3_to_bcd_serial : scoreboard bench for the serial Excess-3 decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xs3_to_bcd_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_xs3 = '0;
  logic              out_ready = 1'b0;
  wire               in_ready;
  wire               out_valid;
  wire [W-1:0]       out_bcd;
  wire [DIGITS-1:0]  out_err_mask;
  wire               out_err;

  xs3_to_bcd_serial #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_xs3       (in_xs3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]      bcd;
    logic [DIGITS-1:0] mask;
    int                acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: manual
  logic manual_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  // Reference: each Excess-3 code c is worth c-3 when 3<=c<=12, otherwise F with error
  function automatic exp_t model(input logic [W-1:0] w, input int acc);
    exp_t e;
    e.bcd  = '0;
    e.mask = '0;
    e.acc  = acc;
    for (int i = 0; i < DIGITS; i++) begin
      int code;
      code = int'((w >> (4 * i)) & W'(15));
      if (code >= 3 && code <= 12) begin
        e.bcd = e.bcd | (W'(code - 3) << (4 * i));
      end else begin
        e.bcd     = e.bcd | (W'(15) << (4 * i));
        e.mask[i] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [3:0] bcd_to_xs3(input int d);
    return 4'(d + 3);
  endfunction

  // Monitor: ready is chosen first so the sampled handshake is the one the next edge sees
  logic              prev_valid = 1'b0;
  logic [W-1:0]      prev_bcd   = '0;
  logic [DIGITS-1:0] prev_mask  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = manual_rdy;
      endcase
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) report_fail("unexpected_valid");
        else check("latency", 64'(cyc - sb[0].acc), 64'(DIGITS));
      end
      if (out_valid && prev_valid) begin
        check("hold_bcd", 64'(out_bcd), 64'(prev_bcd));
        check("hold_mask", 64'(out_err_mask), 64'(prev_mask));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          report_fail("unexpected_result");
        end else begin
          mon_e = sb.pop_front();
          check("out_bcd", 64'(out_bcd), 64'(mon_e.bcd));
          check("out_err_mask", 64'(out_err_mask), 64'(mon_e.mask));
          check("out_err", 64'(out_err), 64'(|mon_e.mask));
        end
      end
      prev_valid = out_valid;
      prev_bcd   = out_bcd;
      prev_mask  = out_err_mask;
    end
  end

  task automatic wait_accept(output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) acc = cyc + 1;
    else begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
    end
  endtask

  task automatic send(input logic [W-1:0] w, input bit use_exp, input logic [W-1:0] eb,
                      input logic [DIGITS-1:0] em, input bit keep, output int acc);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    in_xs3   = w;
    wait_accept(acc, ok);
    if (ok) begin
      e = model(w, acc);
      if (use_exp) begin
        e.bcd  = eb;
        e.mask = em;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           a1, a2;
    logic [W-1:0] w;
    bit           seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_bcd", 64'(out_bcd), 64'(0));
    check("rst_mask", 64'(out_err_mask), 64'(0));
    check("rst_err", 64'(out_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h3456, 1'b1, 16'h0123, 4'b0000, 1'b0, a1);
    drain();
    send(16'h3F20, 1'b1, 16'h0FFF, 4'b0111, 1'b0, a1);
    drain();
    send(16'hCCCC, 1'b1, 16'h9999, 4'b0000, 1'b0, a1);
    drain();

    rdy_mode = 1;
    for (int p = 0; p < DIGITS; p++) begin
      for (int c = 3; c <= 12; c++) begin
        for (int j = 0; j < DIGITS; j++) w[4*j +: 4] = 4'($urandom_range(3, 12));
        w[4*p +: 4] = 4'(c);
        send(w, 1'b0, '0, '0, 1'b0, a1);
      end
    end
    for (int d = 0; d <= 9; d++) begin
      w = {DIGITS{bcd_to_xs3(d)}};
      send(w, 1'b1, {DIGITS{4'(d)}}, '0, 1'b0, a1);
    end
    for (int i = 0; i < 40; i++) send(W'($urandom), 1'b0, '0, '0, 1'b0, a1);
    drain();

    // Backpressure: result must hold and no new word may enter while DONE stalls
    rdy_mode   = 2;
    manual_rdy = 1'b0;
    send(16'h5A3B, 1'b0, '0, '0, 1'b0, a1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bp_valid_timeout: got out_valid=0, expected 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_xs3   = W'($urandom);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid   = 1'b0;
    manual_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    manual_rdy = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    rdy_mode = 0;
    drain();

    // Reset two edges into conversion discards the word
    send(16'h9876, 1'b0, '0, '0, 1'b0, a1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_bcd", 64'(out_bcd), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_mask", 64'(out_err_mask), 64'(0));
    sb.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h4444, 1'b1, 16'h1111, 4'b0000, 1'b0, a1);
    drain();

    send(16'h7B3C, 1'b0, '0, '0, 1'b1, a1);
    send(16'h2C95, 1'b0, '0, '0, 1'b0, a2);
    check("b2b_spacing", 64'(a2 - a1), 64'(DIGITS + 2));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
